riscv_irq_ctrl: RTL and testbench
=================================

Name: riscv_irq_ctrl

Overview:
Machine-level interrupt source block that drives the CSR unit's interrupt request inputs. It provides the CSR unit's intr_req/intr_cause and completes the handshake with the trap_taken acknowledge.
- Hosts the machine timer (mtime/mtimecmp) and the software-interrupt bit (MSIP), accessed through a small register port.
- Synchronises the external interrupt line.
- Arbitrates pending sources against per-source and global enables.
- Exports a mip image for the CSR unit.

Parameters:
TICK_DIV, 1, clk cycles per mtime increment (>=1)
SYNC_STAGES, 2, flops in the ext_irq synchroniser (>=2)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-high despite the name (codebase port name)
reg_addr  in  5  register offset: 0x00 MSIP, 0x04 MTIMECMP lo, 0x08 MTIMECMP hi, 0x0C MTIME lo, 0x10 MTIME hi
reg_wdata  in  32  write data
reg_wen  in  1  write strobe, single cycle
reg_ren  in  1  read strobe, single cycle
reg_rdata  out  32  read data, valid with reg_rvalid
reg_rvalid  out  1  pulses 1 cycle after reg_ren
ext_irq  in  1  asynchronous level external interrupt
mie_global  in  1  mstatus.MIE from CSR unit
mie_en  in  32  mie register from CSR unit (bits 3/7/11 used)
intr_req  out  1  interrupt request to CSR unit
intr_cause  out  4  cause code: 3 MSI, 7 MTI, 11 MEI
intr_ack  in  1  trap_taken from CSR unit
mip_o  out  32  pending image: bit3 MSIP, bit7 MTIP, bit11 MEIP, others 0

Behaviour:
Reset (async, rst_n=1):
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, sync chain=0, FSM=IDLE.
- Outputs intr_req=0, intr_cause=0, reg_rdata=0, reg_rvalid=0, mip_o=0.
- Asserting reset mid-request drops intr_req immediately.

Timer:
- Prescaler counts 0..TICK_DIV-1; mtime increments by 1 at the wrap. With TICK_DIV=1, mtime increments every cycle.
- The 64-bit add wraps FFFF_FFFF_FFFF_FFFF -> 0.
- MTIP is a registered flag, high when mtime >= mtimecmp (unsigned 64-bit).
- A write to MTIME lo/hi replaces only that half and suppresses that cycle's increment; the other half is untouched, with no carry.
- Writes to MTIMECMP lo/hi update that half only. Software writes hi=FFFF_FFFF first to avoid a spurious match.

MSIP:
- Write: msip = wdata[0]. Read returns {31'b0, msip}.

External interrupt:
- ext_irq passes through SYNC_STAGES flops, then MEIP = synchronised level (level-sensitive, no latching).

Register port:
- Reads return the register sampled in the reg_ren cycle, on the next cycle with reg_rvalid=1.
- Unmapped offsets read 0; writes to them are ignored.
- reg_wen and reg_ren in the same cycle: the write commits and the read returns the old value.

Pending, eligibility and arbitration:
- mip_o registered: {20'b0, MEIP, 3'b0, MTIP, 3'b0, MSIP, 3'b0}.
- eligible[i] = mip_o[i] & mie_en[i] & mie_global.
- Fixed priority MEI > MSI > MTI.

FSM:
- IDLE: if any source is eligible, next cycle intr_req=1 and intr_cause = winner; go to REQ.
- REQ:
  - intr_cause is held stable.
  - intr_ack=1 -> intr_req=0 next cycle; go to HOLD.
  - If the latched source stops being eligible before ack (pending cleared, enable dropped, or mie_global=0), withdraw: intr_req=0 next cycle; go to IDLE.
  - A higher-priority source arriving during REQ does NOT pre-empt.
- HOLD: 2 cycles with intr_req=0, to cover the CSR unit's MIE clear; then go to IDLE.
- intr_ack outside REQ is ignored.

Latency:
- Eligible pending -> intr_req: 1 cycle after mip_o updates.
- ext_irq edge -> intr_req: SYNC_STAGES+2 cycles.
- Timer match -> intr_req: 2 cycles.

Decomposition:
- Shared package constants: IRQ_CAUSE_MSI=3, IRQ_CAUSE_MTI=7, IRQ_CAUSE_MEI=11, the register offsets, mip bit indices, and FSM state encodings. The same bit indices serve the CSR unit's mip/mie masks.
- One natural sub-module, riscv_irq_timer: prescaler, mtime, mtimecmp, MTIP compare, and their register writes.

Test Plan:
- Reset then read MTIMECMP hi -> rdata=FFFF_FFFF one cycle later with rvalid=1. Read MTIME lo within 5 cycles -> small nonzero count; intr_req stays 0.
- TICK_DIV=1: write MTIMECMP lo=0x20, hi=0; mie_en[7]=1, mie_global=1 -> MTIP when mtime=0x20, then intr_req=1 with cause=7 two cycles later. Ack -> req=0; write hi=FFFF_FFFF -> MTIP=0; no re-request.
- Raise ext_irq and write MSIP=1 in the same cycle, all enabled -> first cause=11. After ack and HOLD, with ext still high and mie_global still 1, cause=11 again. Drop ext -> cause=3.
- Request MSI (cause=3), then drop mie_global before ack -> intr_req falls next cycle; FSM returns to IDLE; ack pulse afterwards is ignored.
- Write MTIME lo=FFFF_FFFF, hi=0 -> increments give hi=1, lo=0. Write MTIME hi=FFFF_FFFF with lo=FFFF_FFFF -> mtime wraps to 0, and MTIP follows the new compare.
- Assert rst_n while intr_req=1 -> intr_req, mip_o and reg_rvalid go 0 immediately; mtimecmp returns to all ones.

Source files
------------

// File: rtl/riscv_irq_ctrl_pkg.sv
// Shared constants for the machine-level interrupt block: cause codes, register
// offsets, mip/mie bit positions and request FSM encodings.
package riscv_irq_ctrl_pkg;

    localparam logic [3:0] IRQ_CAUSE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CAUSE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CAUSE_MEI = 4'd11;

    localparam int MIP_MSIP_BIT = 3;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    localparam logic [4:0] REG_MSIP        = 5'h00;
    localparam logic [4:0] REG_MTIMECMP_LO = 5'h04;
    localparam logic [4:0] REG_MTIMECMP_HI = 5'h08;
    localparam logic [4:0] REG_MTIME_LO    = 5'h0C;
    localparam logic [4:0] REG_MTIME_HI    = 5'h10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD1 = 2'd2;
    localparam logic [1:0] ST_HOLD2 = 2'd3;

    function automatic logic [31:0] build_mip(input logic meip, input logic mtip, input logic msip);
        logic [31:0] mip;
        mip               = '0;
        mip[MIP_MEIP_BIT] = meip;
        mip[MIP_MTIP_BIT] = mtip;
        mip[MIP_MSIP_BIT] = msip;
        return mip;
    endfunction

endpackage

// File: rtl/riscv_irq_timer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp with half-word software writes,
// and the registered MTIP compare flag.
module riscv_irq_timer
    import riscv_irq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wen,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          tick;

    assign tick = (prescaler == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            prescaler <= '0;
        else if (tick)
            prescaler <= '0;
        else
            prescaler <= prescaler + PW'(1);
    end

    // A software write to either half wins over the tick and never carries.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            mtime <= '0;
        else if (reg_wen && reg_addr == REG_MTIME_LO)
            mtime[31:0] <= reg_wdata;
        else if (reg_wen && reg_addr == REG_MTIME_HI)
            mtime[63:32] <= reg_wdata;
        else if (tick)
            mtime <= mtime + 64'd1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mtimecmp <= '1;
        end else if (reg_wen) begin
            if (reg_addr == REG_MTIMECMP_LO)
                mtimecmp[31:0] <= reg_wdata;
            if (reg_addr == REG_MTIMECMP_HI)
                mtimecmp[63:32] <= reg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            mtip <= 1'b0;
        else
            mtip <= (mtime >= mtimecmp);
    end

endmodule

// File: rtl/riscv_irq_ctrl.sv
// Machine interrupt source block: timer, MSIP, synchronised external line, pending
// image and the request/acknowledge handshake towards the CSR unit.
module riscv_irq_ctrl
    import riscv_irq_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic        reg_ren,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    input  logic        ext_irq,
    input  logic        mie_global,
    input  logic [31:0] mie_en,
    output logic        intr_req,
    output logic [3:0]  intr_cause,
    input  logic        intr_ack,
    output logic [31:0] mip_o
);

    logic [63:0]            mtime;
    logic [63:0]            mtimecmp;
    logic                   mtip;
    logic                   msip;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   meip;
    logic [31:0]            rd_mux;
    logic [31:0]            eligible;
    logic [3:0]             winner;
    logic                   winner_valid;
    logic [1:0]             state;

    riscv_irq_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_wen   (reg_wen),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .mtime     (mtime),
        .mtimecmp  (mtimecmp),
        .mtip      (mtip)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            msip <= 1'b0;
        else if (reg_wen && reg_addr == REG_MSIP)
            msip <= reg_wdata[0];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            ext_sync <= '0;
        else
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
    end

    assign meip = ext_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            mip_o <= '0;
        else
            mip_o <= build_mip(meip, mtip, msip);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_MSIP:        rd_mux = {31'b0, msip};
            REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            REG_MTIME_LO:    rd_mux = mtime[31:0];
            REG_MTIME_HI:    rd_mux = mtime[63:32];
            default:         rd_mux = '0;
        endcase
    end

    // Read data is sampled before any same-cycle write lands.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            reg_rvalid <= reg_ren;
            reg_rdata  <= reg_ren ? rd_mux : '0;
        end
    end

    assign eligible = mip_o & mie_en & {32{mie_global}};

    always_comb begin
        winner       = '0;
        winner_valid = 1'b0;
        if (eligible[MIP_MEIP_BIT]) begin
            winner       = IRQ_CAUSE_MEI;
            winner_valid = 1'b1;
        end else if (eligible[MIP_MSIP_BIT]) begin
            winner       = IRQ_CAUSE_MSI;
            winner_valid = 1'b1;
        end else if (eligible[MIP_MTIP_BIT]) begin
            winner       = IRQ_CAUSE_MTI;
            winner_valid = 1'b1;
        end
    end

    // Cause codes equal their mip bit index, so the latched cause selects its own eligibility.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            intr_req   <= 1'b0;
            intr_cause <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (winner_valid) begin
                        state      <= ST_REQ;
                        intr_req   <= 1'b1;
                        intr_cause <= winner;
                    end
                end
                ST_REQ: begin
                    if (intr_ack) begin
                        state    <= ST_HOLD1;
                        intr_req <= 1'b0;
                    end else if (!eligible[intr_cause]) begin
                        state    <= ST_IDLE;
                        intr_req <= 1'b0;
                    end
                end
                ST_HOLD1: state <= ST_HOLD2;
                ST_HOLD2: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed and randomized bench for riscv_irq_ctrl, checked cycle by cycle against
// a behavioural model of the timer, pending image and request handshake.
module tb_riscv_irq_ctrl;

    localparam int TB_TICK_DIV = 1;
    localparam int TB_SYNC     = 2;

    logic        clk;
    logic        rst_n;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic        reg_ren;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        ext_irq;
    logic        mie_global;
    logic [31:0] mie_en;
    logic        intr_req;
    logic [3:0]  intr_cause;
    logic        intr_ack;
    logic [31:0] mip_o;

    int testsRun  = 0;
    int failCount = 0;

    typedef enum {P_IDLE, P_REQ, P_HOLD} phase_t;

    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    int          m_presc;
    bit          m_msip;
    bit          m_mtip;
    bit          m_sync[$];
    logic [31:0] m_mip;
    bit          m_req;
    logic [3:0]  m_cause;
    phase_t      m_phase;
    int          m_holdLeft;
    bit          m_rvalid;
    logic [31:0] m_rdata;

    logic [4:0]  addrTable [0:7] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C, 5'h02};
    int          prio [0:2] = '{11, 3, 7};

    riscv_irq_ctrl #(
        .TICK_DIV    (TB_TICK_DIV),
        .SYNC_STAGES (TB_SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wen    (reg_wen),
        .reg_ren    (reg_ren),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .ext_irq    (ext_irq),
        .mie_global (mie_global),
        .mie_en     (mie_en),
        .intr_req   (intr_req),
        .intr_cause (intr_cause),
        .intr_ack   (intr_ack),
        .mip_o      (mip_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mtime    = '0;
        m_cmp      = '1;
        m_presc    = 0;
        m_msip     = 1'b0;
        m_mtip     = 1'b0;
        m_sync.delete();
        repeat (TB_SYNC) m_sync.push_back(1'b0);
        m_mip      = '0;
        m_req      = 1'b0;
        m_cause    = '0;
        m_phase    = P_IDLE;
        m_holdLeft = 0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
    endtask

    // One clock edge of the reference: every update reads the pre-edge state.
    task automatic modelStep(input bit wen, input bit ren, input logic [4:0] addr,
                             input logic [31:0] wdata, input bit ack);
        logic [31:0] rd;
        logic [31:0] elig;
        logic [31:0] nextMip;
        logic [3:0]  pick;
        bit          tick;
        case (addr)
            5'h00:   rd = {31'b0, m_msip};
            5'h04:   rd = m_cmp[31:0];
            5'h08:   rd = m_cmp[63:32];
            5'h0C:   rd = m_mtime[31:0];
            5'h10:   rd = m_mtime[63:32];
            default: rd = 32'h0;
        endcase
        elig = m_mip & mie_en & (mie_global ? 32'hFFFF_FFFF : 32'h0);
        pick = 4'd0;
        for (int i = 0; i < 3; i++)
            if (pick == 4'd0 && elig[prio[i]]) pick = 4'(prio[i]);
        case (m_phase)
            P_IDLE: if (pick != 4'd0) begin
                m_req = 1'b1; m_cause = pick; m_phase = P_REQ;
            end
            P_REQ: if (ack) begin
                m_req = 1'b0; m_phase = P_HOLD; m_holdLeft = 2;
            end else if (!elig[m_cause]) begin
                m_req = 1'b0; m_phase = P_IDLE;
            end
            P_HOLD: begin
                m_holdLeft--;
                if (m_holdLeft == 0) m_phase = P_IDLE;
            end
            default: m_phase = P_IDLE;
        endcase
        nextMip     = '0;
        nextMip[11] = m_sync[0];
        nextMip[7]  = m_mtip;
        nextMip[3]  = m_msip;
        m_mip  = nextMip;
        m_mtip = (m_mtime >= m_cmp);
        void'(m_sync.pop_front());
        m_sync.push_back(ext_irq);
        tick    = (m_presc == TB_TICK_DIV - 1);
        m_presc = tick ? 0 : m_presc + 1;
        if (wen && addr == 5'h0C)      m_mtime[31:0]  = wdata;
        else if (wen && addr == 5'h10) m_mtime[63:32] = wdata;
        else if (tick)                 m_mtime        = m_mtime + 64'd1;
        if (wen && addr == 5'h04) m_cmp[31:0]  = wdata;
        if (wen && addr == 5'h08) m_cmp[63:32] = wdata;
        if (wen && addr == 5'h00) m_msip = wdata[0];
        m_rvalid = ren;
        m_rdata  = ren ? rd : 32'h0;
    endtask

    task automatic compareModel();
        checkOutput("intr_req", 64'(intr_req), 64'(m_req));
        if (m_req) checkOutput("intr_cause", 64'(intr_cause), 64'(m_cause));
        checkOutput("mip_o", 64'(mip_o), 64'(m_mip));
        checkOutput("reg_rvalid", 64'(reg_rvalid), 64'(m_rvalid));
        if (m_rvalid) checkOutput("reg_rdata", 64'(reg_rdata), 64'(m_rdata));
    endtask

    task automatic applyStimulus(input bit wen, input bit ren, input logic [4:0] addr,
                                 input logic [31:0] wdata, input bit ack);
        reg_wen   = wen;
        reg_ren   = ren;
        reg_addr  = addr;
        reg_wdata = wdata;
        intr_ack  = ack;
        @(posedge clk);
        modelStep(wen, ren, addr, wdata, ack);
        #1;
        compareModel();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'h00, 32'h0, 1'b0);
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data, 1'b0);
    endtask

    task automatic readReg(input logic [4:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 32'h0, 1'b0);
    endtask

    task automatic ackCycle();
        applyStimulus(1'b0, 1'b0, 5'h00, 32'h0, 1'b1);
    endtask

    task automatic waitReq(input string tag, input int budget);
        int n = 0;
        while (!intr_req && n < budget) begin
            idleCycle();
            n++;
        end
        checkOutput({tag, "_seen"}, 64'(intr_req), 64'(1));
    endtask

    // Reset is raised mid-cycle so its asynchronous effect is observable before any edge.
    task automatic doReset();
        rst_n = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_intr_req", 64'(intr_req), 64'(0));
        checkOutput("rst_intr_cause", 64'(intr_cause), 64'(0));
        checkOutput("rst_mip_o", 64'(mip_o), 64'(0));
        checkOutput("rst_rvalid", 64'(reg_rvalid), 64'(0));
        checkOutput("rst_rdata", 64'(reg_rdata), 64'(0));
        reg_wen  = 1'b0;
        reg_ren  = 1'b0;
        intr_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        reg_addr   = '0;
        reg_wdata  = '0;
        reg_wen    = 1'b0;
        reg_ren    = 1'b0;
        ext_irq    = 1'b0;
        mie_global = 1'b0;
        mie_en     = '0;
        intr_ack   = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        readReg(5'h08);
        checkOutput("cmp_hi_reset", 64'(reg_rdata), 64'(32'hFFFF_FFFF));
        readReg(5'h0C);
        checkOutput("mtime_small", 64'(reg_rdata != 0 && reg_rdata < 5), 64'(1));

        // Timer interrupt
        mie_en     = 32'h0000_0080;
        mie_global = 1'b1;
        writeReg(5'h04, 32'h20);
        writeReg(5'h08, 32'h0);
        waitReq("mti", 100);
        checkOutput("cause_mti", 64'(intr_cause), 64'(7));
        applyStimulus(1'b1, 1'b0, 5'h08, 32'hFFFF_FFFF, 1'b1);
        repeat (8) idleCycle();
        checkOutput("no_rereq", 64'(intr_req), 64'(0));
        checkOutput("mtip_cleared", 64'(mip_o[7]), 64'(0));

        // External and software interrupts together, external wins
        mie_global = 1'b0;
        mie_en     = 32'h0000_0888;
        ext_irq    = 1'b1;
        writeReg(5'h00, 32'h1);
        repeat (4) idleCycle();
        mie_global = 1'b1;
        waitReq("mei1", 20);
        checkOutput("cause_mei1", 64'(intr_cause), 64'(11));
        ackCycle();
        checkOutput("ack_drops_req", 64'(intr_req), 64'(0));
        waitReq("mei2", 20);
        checkOutput("cause_mei2", 64'(intr_cause), 64'(11));
        ext_irq = 1'b0;
        ackCycle();
        waitReq("msi", 20);
        checkOutput("cause_msi", 64'(intr_cause), 64'(3));

        // Withdrawal when the global enable drops before the acknowledge
        mie_global = 1'b0;
        idleCycle();
        checkOutput("withdraw_req", 64'(intr_req), 64'(0));
        ackCycle();
        repeat (3) idleCycle();
        checkOutput("ack_ignored", 64'(intr_req), 64'(0));
        writeReg(5'h00, 32'h0);
        mie_global = 1'b1;
        repeat (4) idleCycle();
        checkOutput("quiet_after_msip_clear", 64'(intr_req), 64'(0));

        // mtime half writes, carry and 64-bit wrap
        mie_en = '0;
        writeReg(5'h0C, 32'hFFFF_FFFF);
        writeReg(5'h10, 32'h0);
        idleCycle();
        readReg(5'h10);
        checkOutput("mtime_carry_hi", 64'(reg_rdata), 64'(1));
        writeReg(5'h0C, 32'hFFFF_FFFF);
        writeReg(5'h10, 32'hFFFF_FFFF);
        idleCycle();
        readReg(5'h10);
        checkOutput("mtime_wrap_hi", 64'(reg_rdata), 64'(0));
        repeat (3) idleCycle();
        checkOutput("mtip_after_wrap", 64'(mip_o[7]), 64'(0));
        readReg(5'h14);
        checkOutput("unmapped_read", 64'(reg_rdata), 64'(0));

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            bit          w;
            bit          r;
            bit          k;
            logic [4:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 9) == 0)  ext_irq    = ~ext_irq;
            if ($urandom_range(0, 7) == 0)  mie_global = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mie_en     = $urandom;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            k = ($urandom_range(0, 3) == 0);
            a = addrTable[$urandom_range(0, 7)];
            d = $urandom;
            applyStimulus(w, r, a, d, k);
        end

        // Reset asserted while a request is outstanding
        mie_global = 1'b0;
        ext_irq    = 1'b0;
        writeReg(5'h00, 32'h1);
        repeat (6) idleCycle();
        mie_en     = 32'h0000_0008;
        mie_global = 1'b1;
        waitReq("pre_reset", 20);
        checkOutput("pre_reset_cause", 64'(intr_cause), 64'(3));
        readReg(5'h04);
        doReset();
        readReg(5'h08);
        checkOutput("cmp_hi_after_reset", 64'(reg_rdata), 64'(32'hFFFF_FFFF));
        readReg(5'h04);
        checkOutput("cmp_lo_after_reset", 64'(reg_rdata), 64'(32'hFFFF_FFFF));
        readReg(5'h00);
        checkOutput("msip_after_reset", 64'(reg_rdata), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
